// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//
// Purpose:
//   Packs decoded instruction fields (R, I, JI, JII formats) into 32-bit
//   machine words and queues them, together with the instruction-memory word
//   address each one will be written to, in a small output FIFO. Requests
//   whose fields cannot be represented are still queued, but as a nop
//   (32'h0). They also raise a sticky error flag that remembers the address
//   of the first such request.
//
// Handshake (both sides):
//   A transfer happens on a rising clock edge when valid and ready are both
//   high. Valid never depends on ready. On the output side, out_instr and
//   out_addr stay stable while out_valid is high and out_ready is low.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset      : asynchronous active-high reset
//   clear      : synchronous flush (FIFO, address counter, error state)
//   in_valid   : encode request present
//   in_ready   : request can be accepted (= !full & !clear)
//   in_type    : 0=R, 1=I, 2=JI, 3=JII
//   in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop : 5-bit fields
//   in_imm     : signed immediate (I type)
//   in_target  : unsigned jump target (JI type)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer takes the head entry
//   out_instr  : head encoded word
//   out_addr   : imem word address of the head entry
//   level      : FIFO occupancy
//   err        : sticky, at least one rejected request since reset/clear
//   err_addr   : address assigned to the first rejected request
// ---------------------------------------------------------------------------
module instruction_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_type,
  input  logic [4:0]                 in_opcode,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_shamt,
  input  logic [4:0]                 in_aluop,
  input  logic [31:0]                in_imm,
  input  logic [31:0]                in_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err,
  output logic [ADDR_W-1:0]          err_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] TYPE_R   = 2'd0;
  localparam logic [1:0] TYPE_I   = 2'd1;
  localparam logic [1:0] TYPE_JI  = 2'd2;
  localparam logic [1:0] TYPE_JII = 2'd3;

  // Storage and bookkeeping
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Encoder
  logic [31:0] enc_word;
  logic        enc_bad;

  logic full;
  logic push;
  logic pop;

  // -------------------------------------------------------------------------
  // Field packing. A request that does not fit its format is replaced by a
  // nop so the consumer always gets a harmless word at that address.
  // -------------------------------------------------------------------------
  always_comb begin
    enc_word = 32'h0;
    enc_bad  = 1'b0;
    case (in_type)
      TYPE_R: begin
        enc_bad  = (in_opcode != 5'd0);
        enc_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      end
      TYPE_I: begin
        // Immediate must survive truncation to 17 bits as a signed value.
        enc_bad  = (in_imm[31:16] != {16{in_imm[16]}});
        enc_word = {in_opcode, in_rd, in_rs, in_imm[16:0]};
      end
      TYPE_JI: begin
        enc_bad  = (in_target[31:27] != 5'd0);
        enc_word = {in_opcode, in_target[26:0]};
      end
      TYPE_JII: begin
        enc_bad  = 1'b0;
        enc_word = {in_opcode, in_rd, 22'd0};
      end
      default: begin
        enc_bad  = 1'b0;
        enc_word = 32'h0;
      end
    endcase
    if (enc_bad) enc_word = 32'h0;
  end

  // -------------------------------------------------------------------------
  // Handshake qualifiers. clear wins over both push and pop; a full FIFO
  // refuses input even when it is being popped in the same cycle.
  // -------------------------------------------------------------------------
  assign full      = (count == LVL_W'(DEPTH));
  assign out_valid = (count != '0);
  assign in_ready  = !full && !clear;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !clear;

  // -------------------------------------------------------------------------
  // Entry storage. Reset zeroes the array so out_instr/out_addr read 0 while
  // reset is held; clear only rewinds pointers (contents become don't-care).
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= 32'h0;
        addr_mem[i]  <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr]  <= addr_cnt;
    end
  end

  // Pointers, occupancy and the imem address counter. DEPTH is a power of
  // two, so the pointers wrap naturally; the address counter likewise wraps
  // from 2^ADDR_W-1 to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error: only the first rejected push after reset/clear records
  // its address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (clear) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (push && enc_bad && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= addr_cnt;
    end
  end

  // Outputs come straight from registered state: no input-to-output path.
  assign out_instr = instr_mem[rd_ptr];
  assign out_addr  = addr_mem[rd_ptr];
  assign level     = count;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_encoder
//
// Directed bench for instruction_encoder. A default build (DEPTH=4,
// ADDR_W=12) covers encoding, rejection, full/empty, clear and reset; a
// second build with ADDR_W=2 covers address-counter wrap. Inputs change #1
// after a rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_instruction_encoder;

  localparam logic [1:0] T_R   = 2'd0;
  localparam logic [1:0] T_I   = 2'd1;
  localparam logic [1:0] T_JI  = 2'd2;
  localparam logic [1:0] T_JII = 2'd3;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Shared request fields
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_type = 2'd0;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
  logic [4:0]  in_shamt = '0, in_aluop = '0;
  logic [31:0] in_imm = '0, in_target = '0;
  logic        out_ready = 1'b0;

  // Default build outputs
  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [11:0] out_addr, err_addr;
  logic [2:0]  level;

  // ADDR_W=2 build signals
  logic        in_valid_b = 1'b0;
  logic        out_ready_b = 1'b1;
  logic        in_ready_b, out_valid_b, err_b;
  logic [31:0] out_instr_b;
  logic [1:0]  out_addr_b, err_addr_b;
  logic [2:0]  level_b;

  int checks = 0;
  int errors = 0;

  instruction_encoder #(.DEPTH(4), .ADDR_W(12)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .level(level),
    .err(err), .err_addr(err_addr)
  );

  instruction_encoder #(.DEPTH(4), .ADDR_W(2)) dut_b (
    .clock(clock), .reset(reset), .clear(1'b0),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_type(in_type),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_instr(out_instr_b), .out_addr(out_addr_b), .level(level_b),
    .err(err_b), .err_addr(err_addr_b)
  );

  // Comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] t, input logic [4:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh,
                         input logic [4:0] alu, input logic [31:0] imm, input logic [31:0] tgt);
    in_type = t; in_opcode = opc; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
  endtask

  task automatic push_one();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_instr, input logic [11:0] exp_addr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_addr"}, {20'd0, out_addr}, {20'd0, exp_addr});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    wrap_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // ---- Reset state (checked while reset is held) ----
    #1 reset = 1'b1;
    #2;
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_addr", {20'd0, err_addr}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", {20'd0, out_addr}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- R encoding, one-cycle latency ----
    set_req(T_R, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'd0, 32'd0);
    push_one();
    check("r_level", {29'd0, level}, 32'd1);
    pop_check("r", 32'h00443000, 12'd0);
    check("r_drained", {29'd0, level}, 32'd0);

    // ---- I / JI / JII encodings from a fresh counter ----
    do_clear();
    set_req(T_I, 5'd5, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0);
    push_one();
    set_req(T_JI, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd100);
    push_one();
    set_req(T_JII, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    push_one();
    check("b_level", {29'd0, level}, 32'd3);
    check("b_err", {31'd0, err}, 32'd0);
    pop_check("b_i", 32'h290BFFFF, 12'd0);
    pop_check("b_ji", 32'h08000064, 12'd1);
    pop_check("b_jii", 32'h27C00000, 12'd2);

    // ---- Rejections, sticky err_addr, no push while full ----
    do_clear();
    set_req(T_R, 5'd0, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 32'd0, 32'd0);
    push_one();
    set_req(T_JII, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    push_one();
    set_req(T_I, 5'd5, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 32'h00010000, 32'd0);
    push_one();
    check("c_err", {31'd0, err}, 32'd1);
    check("c_err_addr", {20'd0, err_addr}, 32'd2);
    set_req(T_JI, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h08000000);
    push_one();
    check("c_err_addr_kept", {20'd0, err_addr}, 32'd2);
    check("c_full_level", {29'd0, level}, 32'd4);
    check("c_full_ready", {31'd0, in_ready}, 32'd0);
    // Offer a request while full and popping: only the pop may happen.
    set_req(T_JII, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    check("c_head_instr", out_instr, 32'h014C7424);
    check("c_head_addr", {20'd0, out_addr}, 32'd0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("c_full_pop_level", {29'd0, level}, 32'd3);
    pop_check("c_jii", 32'h27C00000, 12'd1);
    pop_check("c_bad_i", 32'h00000000, 12'd2);
    pop_check("c_bad_ji", 32'h00000000, 12'd3);
    set_req(T_JI, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h07FFFFFF);
    push_one();
    pop_check("c_ji_max", 32'h17FFFFFF, 12'd4);
    check("c_err_final", {31'd0, err}, 32'd1);
    // Pop on empty must not underflow.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("c_empty_pop", {29'd0, level}, 32'd0);

    // ---- Backpressure: five requests into four entries ----
    do_clear();
    for (int k = 1; k <= 4; k++) begin
      set_req(T_JII, 5'(k), 5'(k), 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      push_one();
    end
    set_req(T_JII, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    in_valid = 1'b1;
    tick();
    check("d_held_level", {29'd0, level}, 32'd4);
    check("d_held_ready", {31'd0, in_ready}, 32'd0);
    check("d_h0_instr", out_instr, 32'h08400000);
    check("d_h0_addr", {20'd0, out_addr}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("d_pop_level", {29'd0, level}, 32'd3);
    check("d_pop_ready", {31'd0, in_ready}, 32'd1);
    check("d_h1_instr", out_instr, 32'h10800000);
    check("d_h1_addr", {20'd0, out_addr}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("d_pushpop_level", {29'd0, level}, 32'd3);
    check("d_h2_instr", out_instr, 32'h18C00000);
    check("d_h2_addr", {20'd0, out_addr}, 32'd2);
    tick();
    check("d_h3_instr", out_instr, 32'h21000000);
    check("d_h3_addr", {20'd0, out_addr}, 32'd3);
    tick();
    check("d_h4_instr", out_instr, 32'h29400000);
    check("d_h4_addr", {20'd0, out_addr}, 32'd4);
    check("d_h4_level", {29'd0, level}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("d_empty", {31'd0, out_valid}, 32'd0);

    // ---- clear beats a pending push ----
    do_clear();
    set_req(T_R, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0);
    push_one();
    set_req(T_JII, 5'd3, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    push_one();
    push_one();
    check("e_level", {29'd0, level}, 32'd3);
    check("e_err", {31'd0, err}, 32'd1);
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    check("e_clear_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("e_level_after", {29'd0, level}, 32'd0);
    check("e_err_after", {31'd0, err}, 32'd0);
    check("e_err_addr_after", {20'd0, err_addr}, 32'd0);
    check("e_valid_after", {31'd0, out_valid}, 32'd0);
    set_req(T_R, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'd0, 32'd0);
    push_one();
    pop_check("e_first", 32'h00443000, 12'd0);

    // ---- Reset mid-transfer ----
    set_req(T_JII, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    push_one();
    push_one();
    reset = 1'b1;
    #1;
    check("f_level", {29'd0, level}, 32'd0);
    check("f_valid", {31'd0, out_valid}, 32'd0);
    check("f_instr", out_instr, 32'd0);
    check("f_addr", {20'd0, out_addr}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("f_ready", {31'd0, in_ready}, 32'd1);
    check("f_level_after", {29'd0, level}, 32'd0);

    // ---- Address wrap on the ADDR_W=2 build ----
    for (int k = 0; k < 5; k++) begin
      set_req(T_JII, 5'(k + 1), 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      check($sformatf("g_valid_%0d", k), {31'd0, out_valid_b}, 32'd1);
      check($sformatf("g_addr_%0d", k), {30'd0, out_addr_b}, {30'd0, wrap_exp[k]});
      tick();
    end
    check("g_level_end", {29'd0, level_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameters: DEPTH, 4, output FIFO entries (power of two, >=2); ADDR_W, 12, instruction-memory word-address width.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous flush: empties FIFO, zeroes address counter and error state.
REQ-005 in_valid  input  1  encode request present.
REQ-006 in_ready  output  1  encoder can accept; = !full & !clear.
REQ-007 in_type  input  2  0=R, 1=I, 2=JI, 3=JII.
REQ-008 in_opcode  input  5  opcode field.
REQ-009 in_rd, in_rs, in_rt, in_shamt, in_aluop  input  5 each  register/shift/ALU fields.
REQ-010 in_imm  input  32  signed immediate (I type).
REQ-011 in_target  input  32  unsigned jump target (JI type).
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer (imem writer) takes head entry.
REQ-014 out_instr  output  32  head encoded word.
REQ-015 out_addr  output  ADDR_W  imem word address of head entry.
REQ-016 level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-017 err  output  1  sticky: at least one rejected request since reset/clear.
REQ-018 err_addr  output  ADDR_W  address assigned to first rejected request.

Function
REQ-019 Push when in_valid & in_ready; pop when out_valid & out_ready; both allowed same cycle.
REQ-020 R encoding: [31:27]=opcode, [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=aluop, [1:0]=0.
REQ-021 I encoding: [31:27]=opcode, [26:22]=rd, [21:17]=rs, [16:0]=imm[16:0].
REQ-022 JI encoding: [31:27]=opcode, [26:0]=target[26:0].
REQ-023 JII encoding: [31:27]=opcode, [26:22]=rd, [21:0]=0.
REQ-024 Reject: R with opcode!=0; I with imm[31:16] not all equal to imm[16]; JI with target[31:27]!=0.
REQ-025 Rejected request still pushes, stored word = 32'h00000000 (nop), consumes an address.
REQ-026 First rejection after reset/clear sets err and captures err_addr; later rejections leave err_addr unchanged.
REQ-027 Address counter assigns current value to each pushed entry, then increments; wraps 2^ADDR_W-1 -> 0.
REQ-028 Latency: push at edge N into empty FIFO -> out_valid=1 at N+1; no combinational in-to-out path.
REQ-029 Full: in_ready=0; no push even if pop same cycle.
REQ-030 Empty: pop ignored; out_instr/out_addr hold last value, don't-care to consumer.
REQ-031 Entries emerge in push order; out_instr/out_addr stable while out_valid & !out_ready.
REQ-032 clear: in_ready=0 that cycle; clear beats push and pop; next cycle level=0, counter=0, err=0, err_addr=0.

Reset
REQ-033 reset asserted: immediately level=0, out_valid=0, counter=0, err=0, err_addr=0, out_instr=0, out_addr=0; in_ready=1 once reset deasserts.
REQ-034 reset mid-transfer discards all FIFO contents; no partial entry survives.

Verification
REQ-035 R: opcode 0, rd 1, rs 2, rt 3, shamt 0, aluop 0 -> out_instr 0x00443000, out_addr 0, next cycle.
REQ-036 I: opcode 5, rd 4, rs 5, imm 0xFFFFFFFF -> 0x290BFFFF; JI opcode 1, target 100 -> 0x08000064; JII opcode 4, rd 31 -> 0x27C00000; addrs 0,1,2.
REQ-037 I imm 0x00010000 as third request -> out_instr 0, err=1, err_addr=2; later bad JI target 0x08000000 leaves err_addr=2.
REQ-038 out_ready=0, push 5 requests -> level=4, in_ready=0, 5th held; raise out_ready -> words in order, addrs 0..4.
REQ-039 Preload counter near wrap (ADDR_W=2 build, 5 pushes) -> addrs 0,1,2,3,0.
REQ-040 clear with in_valid=1 and level=3 -> input not accepted, next cycle level=0, err=0, next push gets addr 0.
